// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state and grant-select encodings.
package mem_arb_pkg;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_PIPE = 2'b01,
    GNT_DBG  = 2'b10
  } gnt_sel_e;

  // Counter width able to hold 0..limit inclusive.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive cycles the debug unit was denied the memory.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int unsigned CntW = cnt_width(STARVE_LIMIT);

  logic [CntW-1:0] cnt_q;

  assign o_at_limit = (cnt_q == CntW'(STARVE_LIMIT));

  // Clear wins over increment; stop counting once the limit is reached.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_inc && !o_at_limit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage and the debug unit.
// Pipeline has priority; a starvation counter forces a debug slot; a debug halt
// hands the memory exclusively to debug.
// Build option: MEMARB_DBG_WRITE_EN adds debug write capability (i_dbg_we/i_dbg_wdata).
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_pipe_req,
  input  logic                  i_pipe_we,
  input  logic [ADDR_WIDTH-1:0] i_pipe_addr,
  input  logic [DATA_WIDTH-1:0] i_pipe_wdata,
  output logic                  o_pipe_stall,
  output logic [DATA_WIDTH-1:0] o_pipe_rdata,
  input  logic                  i_dbg_halt,
  output logic                  o_dbg_halted,
  input  logic                  i_dbg_req,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
`ifdef MEMARB_DBG_WRITE_EN
  input  logic                  i_dbg_we,
  input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
`endif
  output logic                  o_dbg_gnt,
  output logic                  o_dbg_valid,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  arb_state_e            state_q;
  gnt_sel_e              gnt_sel;
  logic                  at_limit;
  logic                  dbg_grant;
  logic                  pipe_grant;
  logic                  dbg_wr;
  logic [DATA_WIDTH-1:0] dbg_wdata;
  logic                  starve_inc;
  logic                  starve_clr;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic                  rd_pend_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

`ifdef MEMARB_DBG_WRITE_EN
  assign dbg_wr    = i_dbg_we;
  assign dbg_wdata = i_dbg_wdata;
`else
  assign dbg_wr    = 1'b0;
  assign dbg_wdata = '0;
`endif

  // Grant decision for this cycle; nothing is granted while reset is held.
  always_comb begin
    dbg_grant  = 1'b0;
    pipe_grant = 1'b0;
    if (i_reset) begin
      if (state_q == S_HALT) begin
        dbg_grant = i_dbg_req;
      end else begin
        dbg_grant  = i_dbg_req & (~i_pipe_req | at_limit);
        pipe_grant = i_pipe_req & ~dbg_grant;
      end
    end
    if (dbg_grant) begin
      gnt_sel = GNT_DBG;
    end else if (pipe_grant) begin
      gnt_sel = GNT_PIPE;
    end else begin
      gnt_sel = GNT_NONE;
    end
  end

  // Memory port mux; the address parks on its last value when idle.
  always_comb begin
    o_mem_addr  = addr_hold_q;
    o_mem_wdata = '0;
    o_mem_we    = 1'b0;
    unique case (gnt_sel)
      GNT_PIPE: begin
        o_mem_addr  = i_pipe_addr;
        o_mem_wdata = i_pipe_wdata;
        o_mem_we    = i_pipe_we;
      end
      GNT_DBG: begin
        o_mem_addr  = i_dbg_addr;
        o_mem_wdata = dbg_wdata;
        o_mem_we    = dbg_wr;
      end
      default: begin
        o_mem_addr  = addr_hold_q;
        o_mem_wdata = '0;
        o_mem_we    = 1'b0;
      end
    endcase
  end

  // Starvation bookkeeping: count denied debug cycles in RUN, drop on any relief.
  assign starve_inc = (state_q == S_RUN) & i_dbg_req & pipe_grant;
  assign starve_clr = dbg_grant | ~i_dbg_req | ((state_q == S_RUN) & i_dbg_halt);

  mem_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_inc     (starve_inc),
    .i_clr     (starve_clr),
    .o_at_limit(at_limit)
  );

  // Combinational outputs are forced low while reset is asserted.
  assign o_pipe_stall = i_reset & i_pipe_req & ~pipe_grant;
  assign o_pipe_rdata = {DATA_WIDTH{i_reset}} & i_mem_rdata;
  assign o_dbg_gnt    = dbg_grant;
  assign o_dbg_halted = (state_q == S_HALT);
  assign o_dbg_valid  = valid_q;
  assign o_dbg_rdata  = rdata_q;

  // FSM, parked address and the two-stage debug read return.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_RUN;
      addr_hold_q <= '0;
      rd_pend_q   <= 1'b0;
      valid_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= i_dbg_halt ? S_HALT : S_RUN;
      addr_hold_q <= o_mem_addr;
      rd_pend_q   <= dbg_grant & ~dbg_wr;
      valid_q     <= rd_pend_q;
      if (rd_pend_q) begin
        rdata_q <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed sequences, a vector table
// and a randomized run against a behavioural reference model.
module tb_mem_access_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pipe_req, pipe_we, pipe_stall;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_wdata, pipe_rdata;
  logic          dbg_halt, dbg_halted, dbg_req, dbg_gnt, dbg_valid, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;

  logic [DW-1:0] mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Synchronous-read single-port memory (read-first).
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[9:2]];
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  mem_access_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_pipe_req  (pipe_req),
    .i_pipe_we   (pipe_we),
    .i_pipe_addr (pipe_addr),
    .i_pipe_wdata(pipe_wdata),
    .o_pipe_stall(pipe_stall),
    .o_pipe_rdata(pipe_rdata),
    .i_dbg_halt  (dbg_halt),
    .o_dbg_halted(dbg_halted),
    .i_dbg_req   (dbg_req),
    .i_dbg_addr  (dbg_addr),
`ifdef MEMARB_DBG_WRITE_EN
    .i_dbg_we    (dbg_we),
    .i_dbg_wdata (dbg_wdata),
`endif
    .o_dbg_gnt   (dbg_gnt),
    .o_dbg_valid (dbg_valid),
    .o_dbg_rdata (dbg_rdata),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_we    (mem_we),
    .i_mem_rdata (mem_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pipe_req = 0; pipe_we = 0; pipe_addr = '0; pipe_wdata = '0;
    dbg_halt = 0; dbg_req = 0; dbg_addr = '0; dbg_we = 0; dbg_wdata = '0;
  endtask

  // LIMIT denied debug cycles, then the forced debug slot and its result.
  task automatic contention(input string tag);
    pipe_req = 1; pipe_we = 0; pipe_addr = 32'h10;
    dbg_req = 1; dbg_addr = 32'h10;
    for (int i = 0; i < LIMIT; i++) begin
      #3;
      check({tag, " early stall"}, pipe_stall, 0);
      check({tag, " early gnt"}, dbg_gnt, 0);
      next();
    end
    #3;
    check({tag, " forced stall"}, pipe_stall, 1);
    check({tag, " forced gnt"}, dbg_gnt, 1);
    next();
    dbg_req = 0;
    #3;
    check({tag, " pipe resumes"}, pipe_stall, 0);
    check({tag, " valid N+1"}, dbg_valid, 0);
    next();
    #3;
    check({tag, " valid N+2"}, dbg_valid, 1);
    check({tag, " rdata"}, dbg_rdata, 32'hDEADBEEF);
    clear_inputs();
    next();
  endtask

  typedef struct {
    logic        preq, pwe, dreq;
    logic [31:0] paddr, daddr;
    logic        stall, gnt, we, chk_addr;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[7];

  // Reference model state
  bit          m_halted;
  int          m_starve;
  logic [31:0] m_last_addr, m_dbg_rdata, m_pipe_rd_data;
  logic [31:0] m_mem [256];
  bit          m_pipe_rd_pend;
  typedef struct {int due; logic [31:0] data;} ret_t;
  ret_t        ret_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp3 [3];
    clear_inputs();
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    #2;
    check("rst stall", pipe_stall, 0);
    check("rst gnt", dbg_gnt, 0);
    check("rst valid", dbg_valid, 0);
    check("rst rdata", dbg_rdata, 0);
    check("rst halted", dbg_halted, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_we", mem_we, 0);
    next(); next();
    rst_n = 1;
    next();

    // 1. Pipe write then read
    pipe_req = 1; pipe_we = 1; pipe_addr = 32'h10; pipe_wdata = 32'hDEADBEEF;
    #3;
    check("t1 wr stall", pipe_stall, 0);
    check("t1 wr we", mem_we, 1);
    check("t1 wr addr", mem_addr, 32'h10);
    check("t1 wr wdata", mem_wdata, 32'hDEADBEEF);
    next();
    pipe_we = 0;
    #3;
    check("t1 rd stall", pipe_stall, 0);
    check("t1 rd we", mem_we, 0);
    next();
    pipe_req = 0;
    #3;
    check("t1 rdata", pipe_rdata, 32'hDEADBEEF);
    check("t1 idle addr hold", mem_addr, 32'h10);
    next();

    // 2. Contention with starvation limit
    contention("t2");

    // 4. Debug alone: granted at once, counter stays at zero
    for (int i = 0; i < 3; i++) begin
      dbg_req = 1; dbg_addr = 32'h10;
      #3;
      check("t4 gnt", dbg_gnt, 1);
      check("t4 stall", pipe_stall, 0);
      next();
    end
    clear_inputs();
    contention("t4");

    // Single-cycle vectors from a clean RUN state, separated by idle cycles
    vecs[0] = '{1, 1, 0, 32'h04, 32'h08, 0, 0, 1, 1, 32'h04};
    vecs[1] = '{1, 0, 0, 32'h0C, 32'h08, 0, 0, 0, 1, 32'h0C};
    vecs[2] = '{0, 0, 1, 32'h04, 32'h28, 0, 1, 0, 1, 32'h28};
    vecs[3] = '{1, 0, 1, 32'h30, 32'h34, 0, 0, 0, 1, 32'h30};
    vecs[4] = '{1, 1, 1, 32'h38, 32'h3C, 0, 0, 1, 1, 32'h38};
    vecs[5] = '{0, 1, 0, 32'h2C, 32'h08, 0, 0, 0, 0, 32'h00};
    vecs[6] = '{0, 1, 1, 32'h2C, 32'h24, 0, 1, 0, 1, 32'h24};
    for (int i = 0; i < 7; i++) begin
      pipe_req = vecs[i].preq; pipe_we = vecs[i].pwe; pipe_addr = vecs[i].paddr;
      pipe_wdata = 32'hA5A50000 + i;
      dbg_req = vecs[i].dreq; dbg_addr = vecs[i].daddr;
      #3;
      check($sformatf("vec%0d stall", i), pipe_stall, vecs[i].stall);
      check($sformatf("vec%0d gnt", i), dbg_gnt, vecs[i].gnt);
      check($sformatf("vec%0d we", i), mem_we, vecs[i].we);
      if (vecs[i].chk_addr) check($sformatf("vec%0d addr", i), mem_addr, vecs[i].addr);
      next();
      clear_inputs();
      next();
    end
    next(); next();

    // 3. Halt: exclusive debug, back-to-back reads
    mem[5] = 32'h11111111;
    mem[6] = 32'h22222222;
    exp3[0] = 32'hDEADBEEF; exp3[1] = 32'h11111111; exp3[2] = 32'h22222222;
    pipe_req = 1; pipe_addr = 32'h10; dbg_halt = 1;
    #3;
    check("t3 first halt cycle stall", pipe_stall, 0);
    check("t3 first halt cycle halted", dbg_halted, 0);
    next();
    for (int k = 0; k < 3; k++) begin
      dbg_req = 1; dbg_addr = 32'h10 + 32'(4 * k);
      #3;
      check($sformatf("t3 halted %0d", k), dbg_halted, 1);
      check($sformatf("t3 stall %0d", k), pipe_stall, 1);
      check($sformatf("t3 gnt %0d", k), dbg_gnt, 1);
      check($sformatf("t3 valid %0d", k), dbg_valid, (k == 2));
      if (k == 2) check("t3 rdata 0", dbg_rdata, exp3[0]);
      next();
    end
    dbg_req = 0;
    #3;
    check("t3 stall 3", pipe_stall, 1);
    check("t3 valid 3", dbg_valid, 1);
    check("t3 rdata 1", dbg_rdata, exp3[1]);
    next();
    dbg_halt = 0;
    #3;
    check("t3 stall 4", pipe_stall, 1);
    check("t3 valid 4", dbg_valid, 1);
    check("t3 rdata 2", dbg_rdata, exp3[2]);
    next();
    #3;
    check("t3 resumed halted", dbg_halted, 0);
    check("t3 resumed stall", pipe_stall, 0);
    check("t3 resumed valid", dbg_valid, 0);
    clear_inputs();
    next();

    // 6. Debug write option
`ifdef MEMARB_DBG_WRITE_EN
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678;
    #3;
    check("t6 gnt", dbg_gnt, 1);
    check("t6 we", mem_we, 1);
    check("t6 addr", mem_addr, 32'h20);
    check("t6 wdata", mem_wdata, 32'h12345678);
    next();
    dbg_req = 0; dbg_we = 0;
    pipe_req = 1; pipe_we = 0; pipe_addr = 32'h20;
    #3;
    check("t6 stall", pipe_stall, 0);
    check("t6 valid N+1", dbg_valid, 0);
    next();
    pipe_req = 0;
    #3;
    check("t6 pipe rdata", pipe_rdata, 32'h12345678);
    check("t6 valid N+2", dbg_valid, 0);
    next();
`else
    mem[8] = 32'hCAFEF00D;
    dbg_req = 1; dbg_addr = 32'h20; pipe_we = 1;
    #3;
    check("t6 gnt", dbg_gnt, 1);
    check("t6 ro we", mem_we, 0);
    next();
    clear_inputs();
    #3;
    check("t6 valid N+1", dbg_valid, 0);
    next();
    #3;
    check("t6 valid N+2", dbg_valid, 1);
    check("t6 rdata", dbg_rdata, 32'hCAFEF00D);
    next();
`endif

    // 5. Reset mid-access drops the in-flight return
    dbg_req = 1; dbg_addr = 32'h10;
    #3;
    check("t5 gnt", dbg_gnt, 1);
    next();
    pipe_req = 1; pipe_addr = 32'h14;
    rst_n = 0;
    #1;
    check("t5 stall", pipe_stall, 0);
    check("t5 gnt0", dbg_gnt, 0);
    check("t5 valid", dbg_valid, 0);
    check("t5 rdata", dbg_rdata, 0);
    check("t5 halted", dbg_halted, 0);
    check("t5 mem_addr", mem_addr, 0);
    check("t5 mem_we", mem_we, 0);
    check("t5 pipe_rdata", pipe_rdata, 0);
    clear_inputs();
    next(); next();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      #3;
      check($sformatf("t5 no valid %0d", i), dbg_valid, 0);
      next();
    end

    // Randomized run against the reference model
    rst_n = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      m_mem[i] = mem[i];
    end
    next(); next();
    rst_n = 1;
    m_halted = 0; m_starve = 0; m_last_addr = '0; m_dbg_rdata = '0; m_pipe_rd_pend = 0;
    ret_q.delete();
    begin
      bit prev_stall = 0, dbg_pending = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        bit dg, pg, d_we_eff, exp_we, exp_valid;
        logic [31:0] exp_addr, exp_wdata;
        if (!prev_stall) begin
          pipe_req = ($urandom % 4) != 0;
          pipe_we = ($urandom % 3) == 0;
          pipe_addr = 32'($urandom_range(0, 15)) << 2;
          pipe_wdata = $urandom;
        end
        if (!dbg_pending) begin
          dbg_req = ($urandom % 2) != 0;
          dbg_addr = 32'($urandom_range(0, 15)) << 2;
`ifdef MEMARB_DBG_WRITE_EN
          dbg_we = ($urandom % 2) != 0;
          dbg_wdata = $urandom;
`endif
        end
        if (($urandom % 16) == 0) dbg_halt = ~dbg_halt;
`ifdef MEMARB_DBG_WRITE_EN
        d_we_eff = dbg_we;
`else
        d_we_eff = 0;
`endif
        if (m_halted) begin
          dg = dbg_req;
          pg = 0;
        end else begin
          dg = dbg_req && (!pipe_req || m_starve >= LIMIT);
          pg = pipe_req && !dg;
        end
        exp_we = pg ? pipe_we : (dg ? d_we_eff : 1'b0);
        exp_addr = pg ? pipe_addr : (dg ? dbg_addr : m_last_addr);
        exp_wdata = pg ? pipe_wdata : dbg_wdata;
        exp_valid = (ret_q.size() > 0) && (ret_q[0].due == cyc);
        if (exp_valid) m_dbg_rdata = ret_q.pop_front().data;
        #3;
        check("rnd stall", pipe_stall, pipe_req && !pg);
        check("rnd gnt", dbg_gnt, dg);
        check("rnd we", mem_we, exp_we);
        check("rnd addr", mem_addr, exp_addr);
        if (exp_we) check("rnd wdata", mem_wdata, exp_wdata);
        check("rnd halted", dbg_halted, m_halted);
        check("rnd valid", dbg_valid, exp_valid);
        check("rnd rdata", dbg_rdata, m_dbg_rdata);
        if (m_pipe_rd_pend) check("rnd pipe_rdata", pipe_rdata, m_pipe_rd_data);
        if (dg && !d_we_eff) ret_q.push_back('{cyc + 2, m_mem[dbg_addr[9:2]]});
        m_pipe_rd_pend = pg && !pipe_we;
        m_pipe_rd_data = m_mem[pipe_addr[9:2]];
        if (exp_we) m_mem[exp_addr[9:2]] = exp_wdata;
        if ((!m_halted && dbg_halt) || dg || !dbg_req) m_starve = 0;
        else if (!m_halted && pg) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        m_halted = dbg_halt;
        m_last_addr = exp_addr;
        prev_stall = pipe_req && !pg;
        dbg_pending = dbg_req && !dg;
        next();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
